// File: rtl/syncgen_pkg.sv
// Shared timing constants and types for the display sync generator (640x480@60 defaults).
package syncgen_pkg;

  localparam int H_PERIOD = 800;
  localparam int H_FRONT  = 16;
  localparam int H_WIDTH  = 96;
  localparam int H_BACK   = 48;
  localparam int V_PERIOD = 525;
  localparam int V_FRONT  = 10;
  localparam int V_WIDTH  = 2;
  localparam int V_BACK   = 33;
  localparam int CW_DEF   = 10;

  typedef logic [CW_DEF-1:0] cnt_t;

endpackage

// File: rtl/syncgen_if.sv
// Video timing bundle from syncgen to pattern/output logic.
// FCNT exists only when SYNCGEN_FRAME_CNT_EN is defined.
interface syncgen_if
  import syncgen_pkg::*;
#(
  parameter int CW = CW_DEF
) ();

  logic [CW-1:0] HCNT;
  logic [CW-1:0] VCNT;
  logic          PHSYNC;
  logic          PVSYNC;
  logic          PDE;
  logic          FSTART;
`ifdef SYNCGEN_FRAME_CNT_EN
  logic [7:0]    FCNT;
`endif

  modport master (
    output HCNT, VCNT, PHSYNC, PVSYNC, PDE, FSTART
`ifdef SYNCGEN_FRAME_CNT_EN
    , output FCNT
`endif
  );

  modport slave (
    input HCNT, VCNT, PHSYNC, PVSYNC, PDE, FSTART
`ifdef SYNCGEN_FRAME_CNT_EN
    , input FCNT
`endif
  );

endinterface

// File: rtl/syncgen_axis.sv
// One timing axis: wrapping counter with count-enable plus terminal/active/sync flags
// decoded combinationally from the current count.
module syncgen_axis #(
  parameter int PERIOD = 800,
  parameter int FRONT  = 16,
  parameter int WIDTH  = 96,
  parameter int BACK   = 48,
  parameter int CW     = 10
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          en_i,
  output logic [CW-1:0] cnt_o,
  output logic          tc_o,
  output logic          act_o,
  output logic          sync_o
);

  localparam logic [31:0] LAST   = 32'(PERIOD - 1);
  localparam logic [31:0] DISP   = 32'(PERIOD - FRONT - WIDTH - BACK);
  localparam logic [31:0] SYNC_S = 32'(PERIOD - WIDTH - BACK);
  localparam logic [31:0] SYNC_E = 32'(PERIOD - BACK);

  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   cnt_w;

  assign cnt_w  = 32'(cnt_q);
  assign tc_o   = (cnt_w == LAST);
  assign act_o  = (cnt_w < DISP);
  assign sync_o = (cnt_w >= SYNC_S) && (cnt_w < SYNC_E);
  assign cnt_o  = cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (en_i) begin
      cnt_d = tc_o ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/syncgen.sv
// Display timing generator: H/V counters with registered syncs, DE and frame-start strobe.
// Optional 8-bit frame counter FCNT under SYNCGEN_FRAME_CNT_EN.
module syncgen
  import syncgen_pkg::*;
#(
  parameter int HPERIOD = H_PERIOD,
  parameter int HFRONT  = H_FRONT,
  parameter int HWIDTH  = H_WIDTH,
  parameter int HBACK   = H_BACK,
  parameter int VPERIOD = V_PERIOD,
  parameter int VFRONT  = V_FRONT,
  parameter int VWIDTH  = V_WIDTH,
  parameter int VBACK   = V_BACK,
  parameter int CW      = CW_DEF
) (
  input  logic       PCK,
  input  logic       RST,
  syncgen_if.master  vid
);

  logic [CW-1:0] hcnt, vcnt;
  logic h_tc, h_act, h_sync;
  logic v_tc, v_act, v_sync;

  logic pde_q, pde_d;
  logic hsync_q, hsync_d;
  logic vsync_q, vsync_d;
  logic fstart_q, fstart_d;
  logic origin_q, origin_d;

  syncgen_axis #(
    .PERIOD(HPERIOD), .FRONT(HFRONT), .WIDTH(HWIDTH), .BACK(HBACK), .CW(CW)
  ) u_haxis (
    .clk_i(PCK), .rst_i(RST), .en_i(1'b1),
    .cnt_o(hcnt), .tc_o(h_tc), .act_o(h_act), .sync_o(h_sync)
  );

  syncgen_axis #(
    .PERIOD(VPERIOD), .FRONT(VFRONT), .WIDTH(VWIDTH), .BACK(VBACK), .CW(CW)
  ) u_vaxis (
    .clk_i(PCK), .rst_i(RST), .en_i(h_tc),
    .cnt_o(vcnt), .tc_o(v_tc), .act_o(v_act), .sync_o(v_sync)
  );

  // origin_q tracks "counters are at (0,0)": true out of reset and after each frame wrap.
  always_comb begin
    pde_d    = h_act & v_act;
    hsync_d  = ~h_sync;
    vsync_d  = ~v_sync;
    fstart_d = origin_q;
    origin_d = h_tc & v_tc;
  end

  always_ff @(posedge PCK or posedge RST) begin
    if (RST) begin
      pde_q    <= 1'b0;
      hsync_q  <= 1'b1;
      vsync_q  <= 1'b1;
      fstart_q <= 1'b0;
      origin_q <= 1'b1;
    end else begin
      pde_q    <= pde_d;
      hsync_q  <= hsync_d;
      vsync_q  <= vsync_d;
      fstart_q <= fstart_d;
      origin_q <= origin_d;
    end
  end

`ifdef SYNCGEN_FRAME_CNT_EN
  logic [7:0] fcnt_q, fcnt_d;
  logic       armed_q, armed_d;

  // The first frame start after reset only arms the counter; later ones count completed frames.
  always_comb begin
    fcnt_d  = fcnt_q;
    armed_d = armed_q;
    if (origin_q) begin
      armed_d = 1'b1;
      if (armed_q) begin
        fcnt_d = fcnt_q + 8'd1;
      end
    end
  end

  always_ff @(posedge PCK or posedge RST) begin
    if (RST) begin
      fcnt_q  <= 8'd0;
      armed_q <= 1'b0;
    end else begin
      fcnt_q  <= fcnt_d;
      armed_q <= armed_d;
    end
  end

  assign vid.FCNT = fcnt_q;
`endif

  assign vid.HCNT   = hcnt;
  assign vid.VCNT   = vcnt;
  assign vid.PHSYNC = hsync_q;
  assign vid.PVSYNC = vsync_q;
  assign vid.PDE    = pde_q;
  assign vid.FSTART = fstart_q;

endmodule

// File: tb/tb_syncgen.sv
// Bench for syncgen: default-timing instance for line checks and a tiny-timing instance
// for frame-level scoreboard checks (and FCNT when SYNCGEN_FRAME_CNT_EN is defined).
module tb_syncgen;
  import syncgen_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_d = 1'b1;
  logic rst_s = 1'b1;

  syncgen_if #(.CW(CW_DEF)) if_d ();
  syncgen_if #(.CW(4))      if_s ();

  syncgen dut_d (.PCK(clk), .RST(rst_d), .vid(if_d));

  syncgen #(
    .HPERIOD(10), .HFRONT(1), .HWIDTH(2), .HBACK(1),
    .VPERIOD(6),  .VFRONT(1), .VWIDTH(1), .VBACK(1), .CW(4)
  ) dut_s (.PCK(clk), .RST(rst_s), .vid(if_s));

  typedef struct {
    logic [3:0] h;
    logic [3:0] v;
    logic       pde;
    logic       hs;
    logic       vs;
    logic       fs;
    logic [7:0] fc;
  } exp_t;

  exp_t sbq[$];
  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int   pde_n, hs_n, hs_first, fs_n, vs_n, pde_rise, last_fs, n_edges;
    logic pde_prev;
    exp_t e;

    // Reset both instances for 5 cycles and check reset values.
    repeat (5) tick();
    chk("rst_hcnt", 32'(if_d.HCNT), 32'd0);
    chk("rst_vcnt", 32'(if_d.VCNT), 32'd0);
    chk("rst_phsync", 32'(if_d.PHSYNC), 32'd1);
    chk("rst_pvsync", 32'(if_d.PVSYNC), 32'd1);
    chk("rst_pde", 32'(if_d.PDE), 32'd0);
    chk("rst_fstart", 32'(if_d.FSTART), 32'd0);
    chk("rst_s_phsync", 32'(if_s.PHSYNC), 32'd1);
    chk("rst_s_pde", 32'(if_s.PDE), 32'd0);
`ifdef SYNCGEN_FRAME_CNT_EN
    chk("rst_fcnt", 32'(if_d.FCNT), 32'd0);
`endif

    // Default timing: one full line after release.
    rst_d = 1'b0;
    pde_n = 0; hs_n = 0; hs_first = -1; fs_n = 0; vs_n = 0; pde_rise = 0; pde_prev = 1'b0;
    for (int k = 1; k <= 800; k++) begin
      tick();
      if (k == 1) begin
        chk("first_fstart", 32'(if_d.FSTART), 32'd1);
        chk("first_pde", 32'(if_d.PDE), 32'd1);
        chk("first_hcnt", 32'(if_d.HCNT), 32'd1);
        chk("first_vcnt", 32'(if_d.VCNT), 32'd0);
      end
      if (if_d.PDE) pde_n++;
      if (if_d.PDE && !pde_prev) pde_rise++;
      pde_prev = if_d.PDE;
      if (!if_d.PHSYNC) begin
        if (hs_first < 0) hs_first = int'(if_d.HCNT);
        hs_n++;
      end
      if (if_d.FSTART) fs_n++;
      if (!if_d.PVSYNC) vs_n++;
    end
    chk("line_pde_cycles", 32'(pde_n), 32'd640);
    chk("line_pde_runs", 32'(pde_rise), 32'd1);
    chk("line_hsync_cycles", 32'(hs_n), 32'd96);
    chk("line_hsync_start", 32'(hs_first), 32'd657);
    chk("line_fstart_cnt", 32'(fs_n), 32'd1);
    chk("line_vsync_idle", 32'(vs_n), 32'd0);
    chk("line_wrap_hcnt", 32'(if_d.HCNT), 32'd0);
    chk("line_wrap_vcnt", 32'(if_d.VCNT), 32'd1);

    // Mid-frame asynchronous reset while PDE is high, then restart from (0,0).
    repeat (300) tick();
    chk("mid_hcnt", 32'(if_d.HCNT), 32'd300);
    chk("mid_vcnt", 32'(if_d.VCNT), 32'd1);
    chk("mid_pde", 32'(if_d.PDE), 32'd1);
    #2;
    rst_d = 1'b1;
    #1;
    chk("arst_hcnt", 32'(if_d.HCNT), 32'd0);
    chk("arst_vcnt", 32'(if_d.VCNT), 32'd0);
    chk("arst_pde", 32'(if_d.PDE), 32'd0);
    chk("arst_phsync", 32'(if_d.PHSYNC), 32'd1);
    chk("arst_pvsync", 32'(if_d.PVSYNC), 32'd1);
    chk("arst_fstart", 32'(if_d.FSTART), 32'd0);
    repeat (2) tick();
    rst_d = 1'b0;
    tick();
    chk("restart_fstart", 32'(if_d.FSTART), 32'd1);
    chk("restart_hcnt", 32'(if_d.HCNT), 32'd1);
    chk("restart_vcnt", 32'(if_d.VCNT), 32'd0);
    rst_d = 1'b1;

    // Small timing: 10x6 total, 6x3 visible, hsync at h 7..8, vsync at v 4.
`ifdef SYNCGEN_FRAME_CNT_EN
    n_edges = 260 * 60 + 1;
`else
    n_edges = 130;
`endif
    rst_s = 1'b0;
    last_fs = -1; vs_n = 0; pde_n = 0;
    for (int k = 1; k <= n_edges; k++) begin
      int p, h, v;
      p = (k - 1) % 60;
      h = p % 10;
      v = p / 10;
      e.h   = 4'((k % 60) % 10);
      e.v   = 4'((k % 60) / 10);
      e.pde = (h < 6) && (v < 3);
      e.hs  = !((h >= 7) && (h < 9));
      e.vs  = (v != 4);
      e.fs  = (p == 0);
      e.fc  = 8'(((k - 1) / 60) % 256);
      sbq.push_back(e);
      tick();
      e = sbq.pop_front();
      chk("s_hcnt", 32'(if_s.HCNT), 32'(e.h));
      chk("s_vcnt", 32'(if_s.VCNT), 32'(e.v));
      chk("s_pde", 32'(if_s.PDE), 32'(e.pde));
      chk("s_phsync", 32'(if_s.PHSYNC), 32'(e.hs));
      chk("s_pvsync", 32'(if_s.PVSYNC), 32'(e.vs));
      chk("s_fstart", 32'(if_s.FSTART), 32'(e.fs));
`ifdef SYNCGEN_FRAME_CNT_EN
      chk("s_fcnt", 32'(if_s.FCNT), 32'(e.fc));
`endif
      if (p == 59) begin
        chk("s_frame_wrap", 32'({if_s.HCNT, if_s.VCNT}), 32'd0);
      end
      if (k <= 60) begin
        if (!if_s.PVSYNC) begin
          if (vs_n == 0) chk("s_vsync_start", 32'({if_s.VCNT, if_s.HCNT}), 32'({4'd4, 4'd1}));
          vs_n++;
        end
        if (if_s.PDE) pde_n++;
      end
      if (if_s.FSTART) begin
        if (last_fs >= 0) chk("s_fstart_period", 32'(k - last_fs), 32'd60);
        last_fs = k;
      end
    end
    chk("s_vsync_cycles", 32'(vs_n), 32'd10);
    chk("s_pde_cycles", 32'(pde_n), 32'd18);
    chk("s_sb_empty", 32'(sbq.size()), 32'd0);

    #3;
    rst_s = 1'b1;
    #1;
    chk("s_arst_hcnt", 32'(if_s.HCNT), 32'd0);
    chk("s_arst_pvsync", 32'(if_s.PVSYNC), 32'd1);
`ifdef SYNCGEN_FRAME_CNT_EN
    chk("s_arst_fcnt", 32'(if_s.FCNT), 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/syncgen.md
# syncgen

Display timing generator driven by the pixel clock `PCK` (25.175 MHz nominal from the board's 125 MHz `SYSCLK`). Runs horizontal and vertical counters and produces HSYNC, VSYNC and display enable for 640x480@60 by default. Sits between the pixel clock generator and the pattern and video output logic. Pattern logic reads `HCNT`/`VCNT` and registers its pixel once, which keeps the pixel aligned with `PDE` and the syncs.

## Interface
Parameters (defaults are the 640x480@60 values):
- `HPERIOD`, 800, total pixels per line
- `HFRONT`, 16, horizontal front porch
- `HWIDTH`, 96, HSYNC pulse width
- `HBACK`, 48, horizontal back porch
- `VPERIOD`, 525, total lines per frame
- `VFRONT`, 10, vertical front porch
- `VWIDTH`, 2, VSYNC pulse width
- `VBACK`, 33, vertical back porch
- `CW`, 10, counter width; must satisfy 2^CW ≥ max(HPERIOD, VPERIOD)

Derived values:
- HDISP = HPERIOD−HFRONT−HWIDTH−HBACK (640)
- VDISP = VPERIOD−VFRONT−VWIDTH−VBACK (480)

Ports (one clock; reset is asynchronous and active-high):
- `PCK`  in  1  pixel clock
- `RST`  in  1  asynchronous active-high reset
- `HCNT`  out  CW  horizontal counter, 0..HPERIOD−1
- `VCNT`  out  CW  vertical counter, 0..VPERIOD−1
- `PHSYNC`  out  1  horizontal sync, active low, registered
- `PVSYNC`  out  1  vertical sync, active low, registered
- `PDE`  out  1  display enable, active high, registered
- `FSTART`  out  1  one-cycle frame-start strobe, registered
- `FCNT`  out  8  frame counter; present only with `SYNCGEN_FRAME_CNT_EN`

## Operation
- `HCNT` increments on every `PCK` edge and wraps from HPERIOD−1 to 0.
- `VCNT` increments only when `HCNT`==HPERIOD−1, and wraps from VPERIOD−1 to 0 at that same edge.
- Each edge registers the following from the current counter values:
  - `PDE` ← (`HCNT` < HDISP) && (`VCNT` < VDISP)
  - `PHSYNC` ← !(HDISP+HFRONT ≤ `HCNT` < HDISP+HFRONT+HWIDTH)
  - `PVSYNC` ← !(VDISP+VFRONT ≤ `VCNT` < VDISP+VFRONT+VWIDTH)
  - `FSTART` ← (`HCNT`==0 && `VCNT`==0)
- Because `VCNT` changes only at the line wrap, `PVSYNC` edges always coincide with a line boundary, one cycle after `HCNT` reaches 0.
- There is no enable input; the block free-runs whenever reset is deasserted.

## Timing
- Reset values: `HCNT`=0, `VCNT`=0, `PHSYNC`=1, `PVSYNC`=1, `PDE`=0, `FSTART`=0, `FCNT`=0.
- Latency: `PDE`, `PHSYNC`, `PVSYNC` and `FSTART` lag the `HCNT`/`VCNT` value they decode by exactly 1 cycle.
- First edge after reset release: `FSTART`=1 and `PDE`=1, because the counters start at (0,0).
- `PDE` is high for exactly HDISP consecutive cycles per visible line, and for VDISP lines per frame.
- `FSTART` is high for exactly 1 cycle in every HPERIOD×VPERIOD cycles (420000 by default).
- Reset asserted mid-frame: all outputs return to their reset values immediately (asynchronous). On release, counting restarts at (0,0) with no partial line.
- Wrap-around: the line wrap and the frame wrap occur on the same edge at (HPERIOD−1, VPERIOD−1). Both counters go to 0; there is no glitch line.

## Configuration
- Macro: `SYNCGEN_FRAME_CNT_EN`.
- Defined:
  - `FCNT` port exists.
  - `FCNT` increments, wrapping 255→0, on the same edge that `FSTART` is registered high, except the first frame after reset, where it stays 0.
  - `FCNT` therefore equals the number of completed frames mod 256.
- Undefined: `FCNT` port and its register are absent; all other behaviour is identical.

## Structure
- Package `syncgen_pkg`:
  - 640x480@60 timing constants (H/V period, front, width, back)
  - default `CW`
  - typedef `cnt_t` (logic [CW-1:0])
- Sub-module `syncgen_axis`, instantiated twice (horizontal, vertical):
  - parameterised by period/front/width/back
  - contains the wrapping counter with a count-enable
  - outputs terminal-count, active-region and sync-region flags
  - the horizontal instance's terminal count drives the vertical instance's count-enable

## Test plan
- Default parameters, reset 5 cycles then release → first edge `FSTART`=1 and `PDE`=1; the next `FSTART` follows exactly 420000 cycles later.
- One full line → `PDE` high for 640 cycles; `PHSYNC` low for exactly 96 cycles, beginning 1 cycle after `HCNT`=656.
- One full frame → `PVSYNC` low for exactly 2×800 cycles, beginning 1 cycle after (`HCNT`=0, `VCNT`=490); `PDE` high on 480 lines.
- Small parameters (HPERIOD=10, HFRONT=1, HWIDTH=2, HBACK=1; VPERIOD=6, VFRONT=1, VWIDTH=1, VBACK=1) → `HCNT` wraps 9→0 with `VCNT` 5→0 on the same edge; `PDE` pattern matches the HDISP=6, VDISP=3 windows.
- Assert `RST` at `HCNT`=300, `VCNT`=200 → all outputs at reset values within the same cycle; after release, counting resumes from (0,0).
- With `SYNCGEN_FRAME_CNT_EN` and small parameters, run 260 frames → `FCNT` reads 0 during frame 0, 1 after the first frame wrap, and wraps 255→0 at the 256th wrap.
